i_o_uart_transmitter: RTL and testbench



---
 rtl/i_o_uart_pkg.sv | 24 ++
 rtl/i_o_uart_transmitter_if.sv | 15 +
 rtl/i_o_sync_fifo.sv | 62 ++++++
 rtl/i_o_uart_transmitter.sv | 124 ++++++++++++
 tb/tb_i_o_uart_transmitter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i_o_uart_pkg.sv
// Shared types and helpers for the I/O UART blocks.
package i_o_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int unsigned DEFAULT_DATA_BITS = 8;
  localparam int unsigned DEFAULT_STOP_BITS = 1;

  // Smallest w with 2**w >= n (0 for n <= 1).
  function automatic int unsigned ceil_log2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/i_o_uart_transmitter_if.sv
// Byte handshake from the I/O register bank into the UART transmitter.
interface i_o_uart_transmitter_if
  import i_o_uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
);

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/i_o_sync_fifo.sv
// Single-clock FIFO; push refused when full, pop ignored when empty.
module i_o_sync_fifo
  import i_o_uart_pkg::*;
#(
  parameter  int unsigned DEPTH   = 4,
  parameter  int unsigned WIDTH   = 8,
  localparam int unsigned PTR_W   = ceil_log2(DEPTH),
  localparam int unsigned COUNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               pop,
  output logic [WIDTH-1:0]   rdata,
  output logic               full,
  output logic               empty,
  output logic [COUNT_W-1:0] count
);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count_q == COUNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/i_o_uart_transmitter.sv
// UART transmitter: FIFO-buffered bytes serialized LSB-first, one bit per baud tick.
module i_o_uart_transmitter
  import i_o_uart_pkg::*;
#(
  parameter  int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
  parameter  int unsigned STOP_BITS  = DEFAULT_STOP_BITS,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned COUNT_W    = ceil_log2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  i_o_uart_transmitter_if.slave in_if,
  output logic                  tx,
  output logic                  busy,
  output logic [COUNT_W-1:0]    fifo_count
);

  localparam int unsigned    IDX_W     = (DATA_BITS > 1) ? ceil_log2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 fifo_push;

  assign in_if.in_ready = ~fifo_full & ~reset;
  assign fifo_push      = in_if.in_valid & in_if.in_ready;

  i_o_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (in_if.in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          tx_d = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            tx_d     = 1'b0;
            state_d  = START;
          end
        end
        START: begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_idx_q == LAST_IDX) begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
        STOP: begin
          tx_d = 1'b1;
          // stop_cnt only climbs to STOP_LAST, so inequality acts as "<"
          if (stop_cnt_q != STOP_LAST) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_i_o_uart_transmitter.sv
// Self-checking bench: frame-level reference model plus directed literal frames.
module tb_i_o_uart_transmitter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  always #5 clk = ~clk;

  i_o_uart_transmitter_if #(.DATA_BITS(8)) in_if ();
  i_o_uart_transmitter_if #(.DATA_BITS(8)) in_if2 ();

  logic       tx, busy, tx2, busy2;
  logic [2:0] cnt, cnt2;

  i_o_uart_transmitter dut (
    .clk(clk), .reset(reset), .tick(tick), .in_if(in_if.slave),
    .tx(tx), .busy(busy), .fifo_count(cnt)
  );

  i_o_uart_transmitter #(.STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .in_if(in_if2.slave),
    .tx(tx2), .busy(busy2), .fifo_count(cnt2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tick generator: periodic, random, or held low.
  int tick_period = 4;
  bit tick_hold = 1'b0;
  bit tick_rand = 1'b0;
  int tcnt = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (tick_hold) tick = 1'b0;
    else if (tick_rand) tick = ($urandom_range(0, 2) == 0);
    else begin
      tcnt++;
      tick = ((tcnt % tick_period) == 0);
    end
  end

  // Reference model: byte queue plus the list of line levels still to send.
  logic [7:0] mq[$];
  logic       mf[$];
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       last_tick = 1'b0;
  logic       m_acc;
  logic [7:0] m_b;
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      mf.delete();
      m_tx = 1'b1;
      m_busy = 1'b0;
      last_tick = 1'b0;
    end else begin
      m_acc = in_if.in_valid && (mq.size() < 4);
      last_tick = tick;
      if (tick) begin
        if (mf.size() > 0) begin
          m_tx = mf.pop_front();
          m_busy = 1'b1;
        end else if (mq.size() > 0) begin
          m_b = mq.pop_front();
          mf.push_back(1'b0);
          for (int i = 0; i < 8; i++) mf.push_back(m_b[i]);
          mf.push_back(1'b1);
          m_tx = mf.pop_front();
          m_busy = 1'b1;
        end else begin
          m_tx = 1'b1;
          m_busy = 1'b0;
        end
      end
      if (m_acc) mq.push_back(in_if.in_data);
    end
  end

  // Per-cycle comparison and per-tick capture of the line.
  bit   cap_en = 1'b0;
  bit   cap2_en = 1'b0;
  logic cap[$];
  logic cap2[$];
  int   busy_cycles = 0;
  initial forever begin
    @(negedge clk);
    check("tx", tx, m_tx);
    check("busy", busy, m_busy);
    check("fifo_count", cnt, mq.size());
    check("in_ready", in_if.in_ready, (!reset && mq.size() < 4));
    if (cap_en && last_tick && (busy || cap.size() > 0)) cap.push_back(tx);
    if (cap2_en && last_tick && (busy2 || cap2.size() > 0)) cap2.push_back(tx2);
    if (busy) busy_cycles++;
  end

  task automatic wait_cap(input int n, input int budget, input string name);
    int c = 0;
    while (cap.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({name, "_timeout"}, (cap.size() >= n), 1);
  endtask

  task automatic push1(input logic [7:0] d);
    logic acc;
    int c = 0;
    @(posedge clk);
    #1;
    in_if.in_valid = 1'b1;
    in_if.in_data = d;
    do begin
      @(negedge clk);
      acc = in_if.in_ready;
      @(posedge clk);
      c++;
    end while (!acc && c < 400);
    #1;
    in_if.in_valid = 1'b0;
    check("push1_timeout", acc, 1);
  endtask

  task automatic push2(input logic [7:0] d);
    logic acc;
    int c = 0;
    @(posedge clk);
    #1;
    in_if2.in_valid = 1'b1;
    in_if2.in_data = d;
    do begin
      @(negedge clk);
      acc = in_if2.in_ready;
      @(posedge clk);
      c++;
    end while (!acc && c < 400);
    #1;
    in_if2.in_valid = 1'b0;
    check("push2_timeout", acc, 1);
  endtask

  logic [10:0] got;
  logic [9:0]  exp_a5 = 10'b1101001010;
  logic [9:0]  exp_3c = 10'b1001111000;
  logic [9:0]  exp_5a = 10'b1010110100;
  logic [10:0] exp_ff2 = 11'b11111111110;
  logic [10:0] exp_002 = 11'b11000000000;
  logic [7:0]  fb;
  logic        held;
  int          k, c, changes;
  bit          full_seen, drop_checked;
  logic        acc;

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_data = '0;
    in_if2.in_valid = 1'b0;
    in_if2.in_data = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", cnt, 0);
    check("rst_in_ready", in_if.in_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single 0xA5 frame at tick period 4.
    cap.delete();
    cap_en = 1'b1;
    busy_cycles = 0;
    push1(8'hA5);
    wait_cap(12, 400, "a5");
    got = '0;
    for (int i = 0; i < 10; i++) got[i] = cap[i];
    check("a5_frame", got[9:0], exp_a5);
    check("a5_idle", {cap[10], cap[11]}, 2'b11);
    check("a5_busy_cycles", busy_cycles, 40);

    // Five back-to-back bytes with in_valid held; FIFO fills while ticks are held.
    @(negedge clk);
    tick_hold = 1'b1;
    cap.delete();
    @(posedge clk);
    #1;
    in_if.in_valid = 1'b1;
    in_if.in_data = 8'h00;
    k = 0;
    c = 0;
    full_seen = 1'b0;
    drop_checked = 1'b0;
    while (k < 5 && c < 400) begin
      @(negedge clk);
      if (k == 4 && !full_seen) begin
        full_seen = 1'b1;
        check("full_in_ready", in_if.in_ready, 0);
        check("full_count", cnt, 4);
        tick_hold = 1'b0;
      end else if (full_seen && !drop_checked && cnt != 3'd4) begin
        drop_checked = 1'b1;
        check("full_pop_count", cnt, 3);
        check("full_pop_refused", k, 4);
      end
      acc = in_if.in_ready;
      @(posedge clk);
      c++;
      #1;
      if (acc) begin
        k++;
        in_if.in_data = k[7:0];
      end
    end
    in_if.in_valid = 1'b0;
    check("burst_accepts", k, 5);
    wait_cap(51, 2000, "burst");
    for (int f = 0; f < 5; f++) begin
      fb = f[7:0];
      got = '0;
      for (int i = 0; i < 10; i++) got[i] = cap[f * 10 + i];
      check("burst_frame", got[9:0], {1'b1, fb, 1'b0});
    end
    check("burst_idle", cap[50], 1);

    // Reset during data bit 3 of 0x81 (bit 3 is low), with bytes queued behind it.
    cap.delete();
    push1(8'h81);
    push1(8'h22);
    push1(8'h33);
    wait_cap(5, 400, "rst_mid");
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_count", cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cap.delete();
    push1(8'h3C);
    wait_cap(10, 400, "3c");
    got = '0;
    for (int i = 0; i < 10; i++) got[i] = cap[i];
    check("3c_frame", got[9:0], exp_3c);

    // Tick held low for 100 clocks mid-frame.
    wait_cap(11, 400, "3c_end");
    cap.delete();
    push1(8'h5A);
    wait_cap(3, 400, "5a_pre");
    tick_hold = 1'b1;
    held = tx;
    changes = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== held) changes++;
    end
    check("hold_tx_frozen", changes, 0);
    check("hold_busy", busy, 1);
    tick_hold = 1'b0;
    wait_cap(11, 400, "5a");
    got = '0;
    for (int i = 0; i < 10; i++) got[i] = cap[i];
    check("5a_frame", got[9:0], exp_5a);
    check("5a_idle", cap[10], 1);

    // Two stop bits on the second instance: 0xFF then 0x00 back-to-back.
    @(negedge clk);
    tick_hold = 1'b1;
    push2(8'hFF);
    push2(8'h00);
    @(negedge clk);
    cap2.delete();
    cap2_en = 1'b1;
    tick_hold = 1'b0;
    c = 0;
    while (cap2.size() < 23 && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("stop2_timeout", (cap2.size() >= 23), 1);
    got = '0;
    for (int i = 0; i < 11; i++) got[i] = cap2[i];
    check("stop2_frame_ff", got, exp_ff2);
    got = '0;
    for (int i = 0; i < 11; i++) got[i] = cap2[11 + i];
    check("stop2_frame_00", got, exp_002);
    check("stop2_idle", cap2[22], 1);
    check("stop2_busy", busy2, 0);
    check("stop2_count", cnt2, 0);
    cap2_en = 1'b0;

    // Random traffic: heavy then sparse, random ticks; the model checks every cycle.
    @(negedge clk);
    tick_rand = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      if (n < 2000) in_if.in_valid = ($urandom_range(0, 1) == 1);
      else in_if.in_valid = ($urandom_range(0, 39) == 0);
      in_if.in_data = 8'($urandom);
    end
    in_if.in_valid = 1'b0;
    c = 0;
    while ((mq.size() != 0 || m_busy) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check("drain_busy", busy, 0);
    check("drain_count", cnt, 0);
    check("drain_tx", tx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
